// File: rtl/muldiv_sequencer_if.sv
// Decode-side bus of the HI/LO multiply/divide unit: operation issue, MTHI/MTLO
// writes, MFHI/MFLO read hazard, and the registered HI/LO results.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mt_hi;
  logic             mt_lo;
  logic [WIDTH-1:0] mt_data;
  logic             read_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, a, b, mt_hi, mt_lo, mt_data, read_req,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, a, b, mt_hi, mt_lo, mt_data, read_req,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide owning the MIPS HI/LO pair.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the shifted multiplier is zero.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  muldiv_sequencer_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t state, state_nx;

  logic [CW-1:0]    count;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic             div_zero;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             op_signed;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [W2-1:0]    acc_nx;
  logic [WIDTH-1:0] mplier_sh;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // Operand conditioning and one iteration of each datapath
  always_comb begin
    op_signed = ~bus.op[0];
    a_abs     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_abs     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    acc_nx    = mplier[0] ? acc + mcand : acc;
    mplier_sh = mplier >> 1;
    rem_sh    = {rem, quo[WIDTH-1]};
    diff      = rem_sh - {1'b0, divisor};
  end

  // Sign fixup applied at the FINISH edge; divide-by-zero returns the raw dividend in HI
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    prod   = (sign_a ^ sign_b) ? -acc : acc;
    if (!is_div) begin
      res_hi = prod[W2-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_hi = sign_a ? -rem : rem;
      res_lo = (sign_a ^ sign_b) ? -quo : quo;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (bus.start) state_nx = S_RUN;
      S_RUN: begin
        if (count == LAST) state_nx = S_FINISH;
`ifdef MULDIV_EARLY_OUT_EN
        else if (!is_div && mplier_sh == '0) state_nx = S_FINISH;
`endif
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      divisor  <= '0;
      quo      <= '0;
      rem      <= '0;
      a_raw    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            count    <= '0;
            is_div   <= bus.op[1];
            sign_a   <= op_signed & bus.a[WIDTH-1];
            sign_b   <= op_signed & bus.b[WIDTH-1];
            div_zero <= (bus.b == '0);
            acc      <= '0;
            mcand    <= W2'(a_abs);
            mplier   <= b_abs;
            divisor  <= b_abs;
            quo      <= a_abs;
            rem      <= '0;
            a_raw    <= bus.a;
          end else begin
            if (bus.mt_hi) hi_q <= bus.mt_data;
            if (bus.mt_lo) lo_q <= bus.mt_data;
          end
        end
        S_RUN: begin
          count  <= count + 1'b1;
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier_sh;
          // Restoring step: keep the trial difference only when it did not borrow
          if (!diff[WIDTH]) rem <= diff[WIDTH-1:0];
          else              rem <= rem_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
        end
        S_FINISH: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = (state == S_FINISH);
  assign bus.stall = bus.read_req & (state != S_IDLE);
endmodule
